// File: rtl/argmax_select.sv
// argmax_select: sequential argmax over N packed IEEE-754 single-precision lanes.
// One lane is examined per cycle; NaN lanes are flagged and never win; ties keep
// the lowest index. idx/nan_seen are registered at done and hold until the next done.
// Optional build macro ARGMAX_MAXVAL_EN adds the max_val output (raw bits of the winner).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; y is latched on the accepting edge
// SCAN  | examining lane k, one per cycle, k = 0..N-1
// FIN   | publish idx/nan_seen(/max_val) and pulse done next cycle
module argmax_select #(
  parameter int S  = 32,
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [S*N-1:0] y,
  input  logic           start,
  output logic [IW-1:0]  idx,
  output logic           nan_seen,
  output logic           busy,
  output logic           done
`ifdef ARGMAX_MAXVAL_EN
  ,
  output logic [S-1:0]   max_val
`endif
);

  // Counter is one bit wider than the index so k never wraps at N = 2**IW.
  localparam int          KW        = IW + 1;
  localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
  localparam logic [S-1:0]  SIGN_MSK = {1'b1, {(S-1){1'b0}}};
  localparam logic [S-1:0]  QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_nx;
  logic          accept;

  logic [S*N-1:0] vec_q;
  logic [KW-1:0]  k_q;
  logic [S-1:0]   best_key_q;
  logic [IW-1:0]  best_idx_q;
  logic           have_best_q;
  logic           nan_run_q;
`ifdef ARGMAX_MAXVAL_EN
  logic [S-1:0]   best_bits_q;
`endif

  logic [S-1:0]   lane_bits;
  logic [S-1:0]   lane_mag;
  logic [S-1:0]   lane_key;
  logic           lane_nan;
  logic           lane_take;

  // State register; reset wins over everything, including a scan in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    state_nx = state_q;
    accept   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (k_q == K_LAST) begin
          state_nx = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Select lane k from the latched vector.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        lane_bits = vec_q[S*i +: S];
      end
    end
  end

  // Total-order key: -0 folds onto +0, positives get the sign bit set,
  // negatives are inverted so larger magnitudes sort lower.
  always_comb begin
    lane_mag  = (lane_bits == SIGN_MSK) ? '0 : lane_bits;
    lane_key  = lane_mag[S-1] ? ~lane_mag : (lane_mag ^ SIGN_MSK);
    lane_nan  = (&lane_bits[30:23]) && (|lane_bits[22:0]);
    lane_take = !lane_nan && (!have_best_q || (lane_key > best_key_q));
  end

  // Scan datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      k_q         <= '0;
      best_key_q  <= '0;
      best_idx_q  <= '0;
      have_best_q <= 1'b0;
      nan_run_q   <= 1'b0;
      idx         <= '0;
      nan_seen    <= 1'b0;
      done        <= 1'b0;
`ifdef ARGMAX_MAXVAL_EN
      best_bits_q <= '0;
      max_val     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            vec_q       <= y;
            k_q         <= '0;
            best_key_q  <= '0;
            best_idx_q  <= '0;
            have_best_q <= 1'b0;
            nan_run_q   <= 1'b0;
          end
        end
        ST_SCAN: begin
          k_q <= k_q + KW'(1);
          if (lane_nan) begin
            nan_run_q <= 1'b1;
          end else if (lane_take) begin
            best_key_q  <= lane_key;
            best_idx_q  <= k_q[IW-1:0];
            have_best_q <= 1'b1;
`ifdef ARGMAX_MAXVAL_EN
            best_bits_q <= lane_bits;
`endif
          end
        end
        ST_FIN: begin
          done     <= 1'b1;
          idx      <= have_best_q ? best_idx_q : '0;
          nan_seen <= nan_run_q;
`ifdef ARGMAX_MAXVAL_EN
          max_val  <= have_best_q ? best_bits_q : QNAN;
`endif
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_select.sv
// Bench for argmax_select: directed vectors plus random vectors against a
// real-valued reference model; checks latency, busy, hold and reset behaviour.
module tb_argmax_select;

  logic        clk;
  logic        rst;
  logic [127:0] y4;
  logic        start4;
  logic [1:0]  idx4;
  logic        nan4, busy4, done4;
  logic [63:0] y2;
  logic        start2;
  logic [0:0]  idx2;
  logic        nan2, busy2, done2;
  logic [31:0] max4, max2;

  int n_cmp  = 0;
  int n_fail = 0;
  int prev_idx4 = 0;
  int prev_idx2 = 0;

  argmax_select #(.S(32), .N(4), .IW(2)) u4 (
    .clk(clk), .rst(rst), .y(y4), .start(start4),
    .idx(idx4), .nan_seen(nan4), .busy(busy4), .done(done4)
`ifdef ARGMAX_MAXVAL_EN
    , .max_val(max4)
`endif
  );

  argmax_select #(.S(32), .N(2), .IW(1)) u2 (
    .clk(clk), .rst(rst), .y(y2), .start(start2),
    .idx(idx2), .nan_seen(nan2), .busy(busy2), .done(done2)
`ifdef ARGMAX_MAXVAL_EN
    , .max_val(max2)
`endif
  );

`ifndef ARGMAX_MAXVAL_EN
  assign max4 = '0;
  assign max2 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Numeric value of a non-NaN single; infinities map beyond any finite single.
  function automatic real f2r(input logic [31:0] b);
    int  e = int'(b[30:23]);
    real m = real'(b[22:0]);
    real mag;
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = m * (2.0 ** (-149));
    else             mag = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -mag : mag;
  endfunction

  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  // Argmax by numeric value; NaNs skipped; first maximum wins.
  task automatic model(input logic [31:0] ln[4], input int n,
                       output int eidx, output bit enan, output logic [31:0] emax);
    int best = -1;
    enan = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (is_nan(ln[i])) enan = 1'b1;
      else if (best < 0 || f2r(ln[i]) > f2r(ln[best])) best = i;
    end
    eidx = (best < 0) ? 0 : best;
    emax = (best < 0) ? 32'h7FC0_0000 : ln[best];
  endtask

  function automatic logic [31:0] rand_lane(input logic [31:0] other);
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[31], 8'hFF, r[22:1], 1'b1};
      1: return {r[31], 8'hFF, 23'd0};
      2: return {r[31], 31'd0};
      3: return other;
      default: return r;
    endcase
  endfunction

  task automatic run4(input logic [31:0] l0, l1, l2, l3, input bit dbl, input string tag);
    logic [31:0] ln[4];
    int eidx; bit enan; logic [31:0] emax;
    int cyc; int pulses;
    ln = '{l0, l1, l2, l3};
    model(ln, 4, eidx, enan, emax);
    y4 = {l3, l2, l1, l0};
    start4 = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy"}, 32'(busy4), 32'd1);
    check({tag, " idx_hold"}, 32'(idx4), 32'(prev_idx4));
    y4 = {$urandom, $urandom, $urandom, $urandom};
    start4 = dbl;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd5);
    check({tag, " idx"}, 32'(idx4), 32'(eidx));
    check({tag, " nan"}, 32'(nan4), 32'(enan));
    check({tag, " busy_done"}, 32'(busy4), 32'd0);
`ifdef ARGMAX_MAXVAL_EN
    check({tag, " max_val"}, max4, emax);
`endif
    prev_idx4 = eidx;
    if (dbl) begin
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (done4) pulses++;
      end
      check({tag, " extra_done"}, 32'(pulses), 32'd0);
    end
  endtask

  task automatic run2(input logic [31:0] l0, l1, input string tag);
    logic [31:0] ln[4];
    int eidx; bit enan; logic [31:0] emax;
    int cyc;
    ln = '{l0, l1, 32'd0, 32'd0};
    model(ln, 2, eidx, enan, emax);
    y2 = {l1, l0};
    start2 = 1'b1;
    @(posedge clk); #1;
    check({tag, " idx_hold"}, 32'(idx2), 32'(prev_idx2));
    start2 = 1'b0;
    y2 = {$urandom, $urandom};
    cyc = 0;
    while (!done2 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd3);
    check({tag, " idx"}, 32'(idx2), 32'(eidx));
    check({tag, " nan"}, 32'(nan2), 32'(enan));
`ifdef ARGMAX_MAXVAL_EN
    check({tag, " max_val"}, max2, emax);
`endif
    prev_idx2 = eidx;
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b, c, d;
    rst = 1'b1; start4 = 1'b0; start2 = 1'b0; y4 = '0; y2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst idx4", 32'(idx4), 32'd0);
    check("rst nan4", 32'(nan4), 32'd0);
    check("rst busy4", 32'(busy4), 32'd0);
    check("rst done4", 32'(done4), 32'd0);
    check("rst idx2", 32'(idx2), 32'd0);
    check("rst busy2", 32'(busy2), 32'd0);
`ifdef ARGMAX_MAXVAL_EN
    check("rst max4", max4, 32'd0);
`endif

    run2(32'h3F00_0000, 32'h3F40_0000, "n2_basic");
    for (int i = 0; i < 12; i++) begin
      a = rand_lane($urandom);
      run2(a, rand_lane(a), "n2_rand");
    end

    run4(32'hC073_3333, 32'h40A0_0000, 32'h3F80_0000, 32'h40A0_0000, 1'b0, "tie");
    run4(32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0, "zero");
    run4(32'h7FC0_0000, 32'h3E80_0000, 32'h7F80_0001, 32'h3E80_0000, 1'b0, "nanmix");
    run4(32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0, "allnan");
    run4(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000, 1'b1, "dblstart");
    run4(32'hFF80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h8000_0001, 1'b0, "inf");

    // Reset two edges into a scan; no done may follow.
    y4 = {32'h4100_0000, 32'h0, 32'h0, 32'h0};
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst idx", 32'(idx4), 32'd0);
    check("midrst busy", 32'(busy4), 32'd0);
    check("midrst done", 32'(done4), 32'd0);
    check("midrst nan", 32'(nan4), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4) pulses++;
    end
    check("midrst no_done", 32'(pulses), 32'd0);
    prev_idx4 = 0;
    prev_idx2 = 0;
    run4(32'h0, 32'h0, 32'h0, 32'h3F80_0000, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      a = rand_lane($urandom);
      b = rand_lane(a);
      c = rand_lane(b);
      d = rand_lane(a);
      run4(a, b, c, d, 1'(i % 5 == 0), "rand4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
